uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_bittimer.sv | 27 ++
 rtl/uart_tx_buffered.sv | 126 ++++++++++++
 tb/tb_uart_tx_buffered.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame-length constants, divider helper.
// Frame length depends on the UART_TX_PARITY_EN build macro.
package uart_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  // Bit period in clk cycles, rounded to the nearest integer.
  function automatic int calc_div(input int clock, input int baud);
    return (clock + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_bittimer.sv
// Bit-period divider: counts 0..DIV-1, restartable; tick marks the last cycle of a bit,
// tick_next the cycle before it.
module uart_tx_bittimer #(
  parameter int DIV = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick,
  output logic tick_next
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_n || restart) cnt <= '0;
    else if (tick)         cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign tick      = (cnt == CNT_W'(DIV - 1));
  assign tick_next = (cnt == CNT_W'(DIV - 2));

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter with one-byte holding register and back-to-back frames (8N1, or 8E1 when
// UART_TX_PARITY_EN is defined). Synchronous active-low reset.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK = 100000000,
  parameter int BAUD  = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       ready,
  output logic       busy,
  output logic       tx,
  output logic       tx_done
);

  localparam int DIV = calc_div(CLOCK, BAUD);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_buffered: bit period DIV must be at least 2 clk cycles");
  end

  tx_state_e  state;
  logic [7:0] hold_data;
  logic       hold_valid;
  logic [7:0] shift;
  logic [2:0] bit_idx;
`ifdef UART_TX_PARITY_EN
  logic       parity;
`endif

  logic tick, tick_next;
  logic stop_end, start_frame, accept;

  assign stop_end    = (state == ST_STOP) && tick;
  // A byte arriving on the very edge STOP ends bypasses the holding register.
  assign start_frame = ((state == ST_IDLE) && hold_valid) ||
                       (stop_end && (hold_valid || tx_start));
  assign accept      = tx_start && !hold_valid;

  uart_tx_bittimer #(.DIV(DIV)) u_bittimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (start_frame),
    .tick      (tick),
    .tick_next (tick_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      hold_valid <= 1'b0;
      bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      tx_done <= (state == ST_STOP) && tick_next;

      // NOTE: hold_data and shift are data-path storage qualified by hold_valid/state, so they need no reset.
      if (start_frame && hold_valid)    hold_valid <= 1'b0;
      else if (accept && !start_frame) begin
        hold_valid <= 1'b1;
        hold_data  <= tx_byte;
      end

      if (start_frame) begin
        state   <= ST_START;
        tx      <= 1'b0;
        shift   <= hold_valid ? hold_data : tx_byte;
        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        parity  <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE:  tx <= 1'b1;
          ST_START: if (tick) begin
            state <= ST_DATA;
            tx    <= shift[0];
          end
          ST_DATA: if (tick) begin
`ifdef UART_TX_PARITY_EN
            parity <= parity ^ shift[0];
`endif
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              tx    <= parity ^ shift[0];
`else
              state <= ST_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: if (tick) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
`endif
          ST_STOP: if (tick) begin
            state <= ST_IDLE;
            tx    <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ready = !hold_valid;
  assign busy  = (state != ST_IDLE) || hold_valid;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at CLOCK=1 MHz, BAUD=100 kbit/s (10 clk cycles per bit).
// Index i of a run is the sample taken before edge i; a write driven at index 0 starts its frame at index 2.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CLOCK = 1000000;
  localparam int BAUD  = 100000;
  localparam int DIV   = 10;
  localparam int FL    = FRAME_BITS * DIV;
  localparam int N     = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_start = 1'b0;
  logic       ready, busy, tx, tx_done;

  uart_tx_buffered #(.CLOCK(CLOCK), .BAUD(BAUD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_byte  (tx_byte),
    .tx_start (tx_start),
    .ready    (ready),
    .busy     (busy),
    .tx       (tx),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic       exp_tx   [N];
  logic       exp_done [N];
  logic       cap_tx   [N];
  logic       cap_done [N];
  logic       cap_ready[N];
  logic       cap_busy [N];
  logic       drv_start[N];
  logic [7:0] drv_byte [N];
  logic       drv_rst  [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    logic [7:0] v;
    v = b;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return v[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^v;
`endif
    return 1'b1;
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < N; i++) begin
      exp_tx[i]    = 1'b1;
      exp_done[i]  = 1'b0;
      drv_start[i] = 1'b0;
      drv_byte[i]  = 8'h00;
      drv_rst[i]   = 1'b0;
    end
  endtask

  task automatic place_frame(input logic [7:0] b, input int s);
    for (int k = 0; k < FL; k++) exp_tx[s+k] = frame_bit(b, k / DIV);
    exp_done[s+FL-1] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tx_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cap_tx[i]    = tx;
      cap_done[i]  = tx_done;
      cap_ready[i] = ready;
      cap_busy[i]  = busy;
      tx_start     = drv_start[i];
      tx_byte      = drv_byte[i];
      rst_n        = !drv_rst[i];
      @(posedge clk);
      #1;
    end
    tx_start = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic check_window(input string t, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s tx[%0d]", t, i), 32'(cap_tx[i]), 32'(exp_tx[i]));
      check($sformatf("%s tx_done[%0d]", t, i), 32'(cap_done[i]), 32'(exp_done[i]));
    end
  endtask

  initial begin
    // Reset state.
    do_reset();
    check("reset tx", 32'(tx), 32'd1);
    check("reset ready", 32'(ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset tx_done", 32'(tx_done), 32'd0);

    // Single byte 0xA5 from idle.
    clear_plan();
    drv_start[0] = 1'b1; drv_byte[0] = 8'hA5;
    place_frame(8'hA5, 2);
    run(2 + FL + 12);
    check_window("a5", 2 + FL + 12);
    check("a5 ready after accept", 32'(cap_ready[1]), 32'd0);
    check("a5 busy after accept", 32'(cap_busy[1]), 32'd1);
    check("a5 ready after load", 32'(cap_ready[2]), 32'd1);
    check("a5 busy end", 32'(cap_busy[2+FL]), 32'd0);

    // Two buffered writes plus an ignored third write while ready=0.
    do_reset();
    clear_plan();
    drv_start[0]  = 1'b1; drv_byte[0]  = 8'h00;
    drv_start[10] = 1'b1; drv_byte[10] = 8'hFF;
    drv_start[20] = 1'b1; drv_byte[20] = 8'h55;
    place_frame(8'h00, 2);
    place_frame(8'hFF, 2 + FL);
    run(2 + 2*FL + 20);
    check_window("b2b", 2 + 2*FL + 20);
    check("b2b ready held", 32'(cap_ready[11]), 32'd0);
    check("b2b ready before load", 32'(cap_ready[1+FL]), 32'd0);
    check("b2b ready after load", 32'(cap_ready[2+FL]), 32'd1);
    check("b2b busy mid gap", 32'(cap_busy[1+FL]), 32'd1);
    check("b2b busy last", 32'(cap_busy[1+2*FL]), 32'd1);
    check("b2b busy idle", 32'(cap_busy[2+2*FL]), 32'd0);

    // Write on the edge STOP ends with the holding register empty.
    do_reset();
    clear_plan();
    drv_start[0]    = 1'b1; drv_byte[0]    = 8'h3C;
    drv_start[1+FL] = 1'b1; drv_byte[1+FL] = 8'hC3;
    place_frame(8'h3C, 2);
    place_frame(8'hC3, 2 + FL);
    run(2 + 2*FL + 10);
    check_window("edge", 2 + 2*FL + 10);
    check("edge ready", 32'(cap_ready[2+FL]), 32'd1);
    check("edge busy", 32'(cap_busy[2+FL]), 32'd1);

    // Reset at cycle 35 of a frame, with a second byte held.
    do_reset();
    clear_plan();
    drv_start[0]  = 1'b1; drv_byte[0]  = 8'h0F;
    drv_start[10] = 1'b1; drv_byte[10] = 8'h99;
    drv_rst[36]   = 1'b1;
    place_frame(8'h0F, 2);
    for (int i = 37; i < N; i++) begin
      exp_tx[i]   = 1'b1;
      exp_done[i] = 1'b0;
    end
    run(200);
    check_window("rst", 200);
    check("rst ready before", 32'(cap_ready[36]), 32'd0);
    check("rst ready after", 32'(cap_ready[37]), 32'd1);
    check("rst busy after", 32'(cap_busy[37]), 32'd0);
    check("rst busy later", 32'(cap_busy[150]), 32'd0);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0.
    do_reset();
    clear_plan();
    drv_start[0]  = 1'b1; drv_byte[0]  = 8'h07;
    drv_start[10] = 1'b1; drv_byte[10] = 8'h03;
    place_frame(8'h07, 2);
    place_frame(8'h03, 2 + FL);
    run(2 + 2*FL + 10);
    check_window("par", 2 + 2*FL + 10);
    check("par 07 bit", 32'(cap_tx[2+90]), 32'd1);
    check("par 03 bit", 32'(cap_tx[2+FL+90]), 32'd0);
    check("par done", 32'(cap_done[2+109]), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
